// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning N:1 multiplexer: FSM state type and
// default parameter values.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_DWELL = 4;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for scan mode: counts 0..DWELL-1 and flags the terminal
// count so the owner can advance the channel on the same edge it wraps.
module dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  // Terminal count: the count value at which the next increment wraps to 0.
  always_comb begin
    tc = (cnt == LAST);
  end

  // Clear has priority over counting; count wraps to 0 after LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// N:1 registered multiplexer with manual channel select and auto-scan mode.
// Channel selection and the HOLD/MANUAL/SCAN FSM live here; the dwell timing
// is delegated to dwell_counter.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned DWELL = DEF_DWELL,
  localparam int unsigned SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           sel_load,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic [SW-1:0]  cur_sel,
  output logic           sel_err
);

  localparam logic [SW:0] NUM_CH = (SW+1)'(N);

  state_t        state_q, state_d;
  logic          mode_q, mode_vld;
  logic          sel_ok, sel_take, mode_chg, scan_now;
  logic          cnt_clr, cnt_inc, cnt_tc, advance, at_last;
  logic [W-1:0]  ch_data;

  // Current-cycle state is decided directly from en/mode every cycle.
  always_comb begin
    state_d = ST_HOLD;
    if (en) begin
      state_d = mode ? ST_SCAN : ST_MANUAL;
    end
  end

  // State register; its value reflects whether the previous cycle was active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  assign y_valid = (state_q != ST_HOLD);

  // Remember the last sampled mode; the valid flag stops the first edge after
  // reset from being treated as a mode change, so scanning out of reset gets
  // a full dwell period on channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      mode_vld <= 1'b0;
    end else begin
      mode_q   <= mode;
      mode_vld <= 1'b1;
    end
  end

  // Select/dwell control: a legal load beats a scan advance, and both a load
  // and a mode change restart the dwell period without moving the channel.
  always_comb begin
    sel_ok   = ({1'b0, sel} < NUM_CH);
    sel_take = sel_load && sel_ok;
    mode_chg = mode_vld && (mode != mode_q);
    scan_now = (state_d == ST_SCAN);
    cnt_clr  = sel_take || mode_chg;
    cnt_inc  = scan_now && !cnt_clr;
    advance  = cnt_inc && cnt_tc;
    at_last  = ({1'b0, cur_sel} == (NUM_CH - 1'b1));
  end

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .tc   (cnt_tc)
  );

  // Channel select register; wraps N-1 -> 0 so out-of-range values never occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel <= '0;
    end else if (sel_take) begin
      cur_sel <= sel;
    end else if (advance) begin
      cur_sel <= at_last ? '0 : cur_sel + 1'b1;
    end
  end

  // Channel extraction from the flattened input bus.
  always_comb begin
    ch_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if ({1'b0, cur_sel} == (SW+1)'(k)) begin
        ch_data = in_data[k*W +: W];
      end
    end
  end

  // Output data register, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (state_d != ST_HOLD) begin
      y <= ch_data;
    end
  end

  // One-cycle error pulse for an out-of-range select load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_load && !sel_ok;
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: three instances (N/DWELL = 4/4, 3/2,
// 5/1) share stimulus and are compared every cycle with a behavioural model.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] in_data;
  logic [2:0]  sel;
  logic        sel_load, mode, en;

  logic [7:0]  y_a, y_b, y_c;
  logic        yv_a, yv_b, yv_c;
  logic        err_a, err_b, err_c;
  logic [1:0]  cs_a, cs_b;
  logic [2:0]  cs_c;

  int tests = 0;
  int fails = 0;

  localparam int NP[3]  = '{4, 3, 5};
  localparam int DP[3]  = '{4, 2, 1};
  localparam int SWP[3] = '{2, 2, 3};

  // Behavioural model state
  int m_y[3]   = '{default: 0};
  int m_yv[3]  = '{default: 0};
  int m_cs[3]  = '{default: 0};
  int m_err[3] = '{default: 0};
  int m_cnt[3] = '{default: 0};
  int m_mq     = 0;
  int m_mv     = 0;

  always #5 clk = ~clk;

  mux_scan_nx1 #(.N(4), .W(8), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[31:0]), .sel(sel[1:0]),
    .sel_load(sel_load), .mode(mode), .en(en),
    .y(y_a), .y_valid(yv_a), .cur_sel(cs_a), .sel_err(err_a));

  mux_scan_nx1 #(.N(3), .W(8), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .sel(sel[1:0]),
    .sel_load(sel_load), .mode(mode), .en(en),
    .y(y_b), .y_valid(yv_b), .cur_sel(cs_b), .sel_err(err_b));

  mux_scan_nx1 #(.N(5), .W(8), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .sel_load(sel_load), .mode(mode), .en(en),
    .y(y_c), .y_valid(yv_c), .cur_sel(cs_c), .sel_err(err_c));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // Model: per edge, apply the select/scan/freeze rules with plain arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_y[i] <= 0; m_yv[i] <= 0; m_cs[i] <= 0; m_err[i] <= 0; m_cnt[i] <= 0;
      end
      m_mq <= 0;
      m_mv <= 0;
    end else begin
      m_mq <= int'(mode);
      m_mv <= 1;
      for (int i = 0; i < 3; i++) begin
        int s;
        bit ld, mchg;
        s    = int'(sel) % (1 << SWP[i]);
        ld   = sel_load && (s < NP[i]);
        mchg = (m_mv != 0) && (int'(mode) != m_mq);
        m_err[i] <= (sel_load && s >= NP[i]) ? 1 : 0;
        m_yv[i]  <= en ? 1 : 0;
        if (en) m_y[i] <= int'((in_data >> (8 * m_cs[i])) & 40'hff);
        if (ld) begin
          m_cs[i]  <= s;
          m_cnt[i] <= 0;
        end else if (mchg) begin
          m_cnt[i] <= 0;
        end else if (en && mode) begin
          if (m_cnt[i] + 1 == DP[i]) begin
            m_cnt[i] <= 0;
            m_cs[i]  <= (m_cs[i] + 1) % NP[i];
          end else begin
            m_cnt[i] <= m_cnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int i, input logic [7:0] y,
                     input logic yv, input int cs, input logic err);
    chk({nm, "_y"},       int'(y),   m_y[i]);
    chk({nm, "_y_valid"}, int'(yv),  m_yv[i]);
    chk({nm, "_cur_sel"}, cs,        m_cs[i]);
    chk({nm, "_sel_err"}, int'(err), m_err[i]);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("a", 0, y_a, yv_a, int'(cs_a), err_a);
    cmp("b", 1, y_b, yv_b, int'(cs_b), err_b);
    cmp("c", 2, y_c, yv_c, int'(cs_c), err_c);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int seq[8] = '{0, 0, 1, 1, 2, 2, 0, 0};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; sel_load = 1'b0;
    in_data = 40'h55_44_33_22_11;
    repeat (3) tick();
    chk("reset_y", int'(y_a), 0);
    chk("reset_y_valid", int'(yv_a), 0);
    chk("reset_cur_sel", int'(cs_a), 0);
    chk("reset_sel_err", int'(err_a), 0);
    rst_n = 1'b1;

    // Manual load of channel 2
    en = 1'b1; mode = 1'b0; sel = 3'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("manual_cur_sel", int'(cs_a), 2);
    tick();
    chk("manual_y", int'(y_a), 'h33);
    chk("manual_y_valid", int'(yv_a), 1);

    // Scan from reset: N=3/DWELL=2 pattern, N=5/DWELL=1 advances every cycle
    rst_n = 1'b0; mode = 1'b1; en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("scan_b_cs0", int'(cs_b), 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("scan_b_cs%0d", k), int'(cs_b), seq[k]);
      chk($sformatf("scan_b_y%0d", k), int'(y_b), 'h11 * (seq[k-1] + 1));
      chk($sformatf("scan_c_cs%0d", k), int'(cs_c), k % 5);
    end

    // Illegal select on N=3 (legal on N=4)
    mode = 1'b0;
    tick();
    sel = 3'd3; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("illegal_err_b", int'(err_b), 1);
    chk("illegal_cs_b", int'(cs_b), 0);
    chk("legal_err_a", int'(err_a), 0);
    chk("legal_cs_a", int'(cs_a), 3);
    tick();
    chk("illegal_err_b_drop", int'(err_b), 0);
    chk("illegal_cs_b_hold", int'(cs_b), 0);

    // Load colliding with a scan advance (DWELL=4)
    mode = 1'b1;
    tick();
    sel = 3'd1; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    repeat (3) tick();
    chk("collide_pre_cs", int'(cs_a), 1);
    sel = 3'd0; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    chk("collide_cs", int'(cs_a), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("collide_hold_cs", int'(cs_a), 0);
    end
    tick();
    chk("collide_next_adv", int'(cs_a), 1);

    // Freeze mid-dwell
    repeat (2) tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("freeze_cs", int'(cs_a), 1);
      chk("freeze_y_valid", int'(yv_a), 0);
      chk("freeze_y", int'(y_a), 'h22);
    end
    en = 1'b1;
    tick();
    chk("resume_cs", int'(cs_a), 1);
    chk("resume_y_valid", int'(yv_a), 1);
    tick();
    chk("resume_adv", int'(cs_a), 2);

    // Asynchronous reset between edges during scan
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_y", int'(y_a), 0);
    chk("async_cs", int'(cs_a), 0);
    chk("async_y_valid", int'(yv_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("restart_cs", int'(cs_a), 0);
    end
    tick();
    chk("restart_adv", int'(cs_a), 1);

    // Randomized traffic, checked by the every-cycle compare
    for (int n = 0; n < 1500; n++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel_load = ($urandom_range(0, 7) == 0);
      sel      = 3'($urandom_range(0, 7));
      in_data  = 40'({$urandom(), $urandom()});
      if (n == 700) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
